ets_phase_sweeper: RTL and testbench

ETS_PHASE_SWEEPER -- requirements
Module: ets_phase_sweeper

---
 rtl/ets_pkg.sv | 28 ++
 rtl/ets_phase_sweeper_if.sv | 19 +
 rtl/ets_hit_counter.sv | 43 ++++
 rtl/ets_phase_sweeper.sv | 162 ++++++++++++++++
 tb/tb_ets_phase_sweeper.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ets_pkg.sv
// ets_pkg
// Shared definitions for the ETS phase sweeper:
//   CNT_W      - width of every step/sample/timeout counter and result field
//   cnt_t      - counter type of that width
//   state_t    - sweep FSM states
//   last_index - terminal count (n-1) for an n-cycle window, 0 when n is 0
package ets_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SAMPLE    = 3'd2,
    ST_EMIT      = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_WAIT_PS   = 3'd5,
    ST_SETTLE    = 3'd6
  } state_t;

  // A zero-length window collapses onto a single cycle, so its last index is 0.
  function automatic cnt_t last_index(input int n);
    return (n > 0) ? cnt_t'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/ets_phase_sweeper_if.sv
// ets_phase_sweeper_if
// Result handshake between the sweeper and its consumer.
//   res_valid - result available (sweeper -> consumer)
//   res_ready - consumer accepts the result this cycle
//   res_step  - phase step index of the result
//   res_count - number of comparator hits seen in that step
// Modports: master = sweeper side, slave = consumer side.
interface ets_phase_sweeper_if;
  import ets_pkg::*;

  logic res_valid;
  logic res_ready;
  cnt_t res_step;
  cnt_t res_count;

  modport master (output res_valid, output res_step, output res_count, input res_ready);
  modport slave  (input res_valid, input res_step, input res_count, output res_ready);

endinterface

// File: rtl/ets_hit_counter.sv
// ets_hit_counter
// Windowed sample/hit counter used while the sweeper is sampling.
//   free_run_clk, free_run_rst_n - clock and synchronous active-low reset
//   clear       - zero both counters (held while not sampling)
//   enable      - count this cycle as a sample
//   sample_bit  - comparator bit for this cycle
//   window_last - this enabled cycle is the final sample of the window
//   window_hits - hit total including this cycle's bit (valid with window_last)
module ets_hit_counter
  import ets_pkg::*;
#(
  parameter int WINDOW = 256
) (
  input  logic free_run_clk,
  input  logic free_run_rst_n,
  input  logic clear,
  input  logic enable,
  input  logic sample_bit,
  output logic window_last,
  output cnt_t window_hits
);

  localparam cnt_t LAST = last_index(WINDOW);

  cnt_t sample_cnt_reg;
  cnt_t hit_cnt_reg;

  always_ff @(posedge free_run_clk) begin
    if (!free_run_rst_n || clear) begin
      sample_cnt_reg <= '0;
      hit_cnt_reg    <= '0;
    end else if (enable) begin
      sample_cnt_reg <= sample_cnt_reg + cnt_t'(1);
      hit_cnt_reg    <= hit_cnt_reg + cnt_t'(sample_bit);
    end
  end

  // The final sample is folded in combinationally so the result is ready
  // in the same cycle the window closes.
  assign window_last = enable && (sample_cnt_reg == LAST);
  assign window_hits = hit_cnt_reg + cnt_t'(sample_bit);

endmodule

// File: rtl/ets_phase_sweeper.sv
// ets_phase_sweeper
// Steps an MMCM output phase across a full sweep, and at each step counts
// how many of SAMPLE_COUNT comparator samples are 1, reporting one result
// per step over a valid/ready handshake.
// Ports:
//   free_run_clk, free_run_rst_n - clock, synchronous active-low reset
//   start / abort                - begin a sweep / abandon it immediately
//   locked                       - MMCM lock; sampling only counts while locked
//   cmp_data                     - synchronous comparator bit
//   ps_en, ps_incdec, ps_done    - MMCM dynamic phase-shift port
//   busy, done, err_timeout      - status (done is a pulse, err_timeout sticky)
//   res                          - result handshake (master side)
module ets_phase_sweeper
  import ets_pkg::*;
#(
  parameter int STEP_COUNT    = 1024,
  parameter int SAMPLE_COUNT  = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int PS_TIMEOUT    = 255
) (
  input  logic free_run_clk,
  input  logic free_run_rst_n,
  input  logic start,
  input  logic abort,
  input  logic locked,
  input  logic cmp_data,
  output logic ps_en,
  output logic ps_incdec,
  input  logic ps_done,
  output logic busy,
  output logic done,
  output logic err_timeout,
  ets_phase_sweeper_if.master res
);

  localparam cnt_t STEP_LAST   = last_index(STEP_COUNT);
  localparam cnt_t SETTLE_LAST = last_index(SETTLE_CYCLES);
  localparam cnt_t TMO_LAST    = last_index(PS_TIMEOUT);

  state_t state_reg;
  cnt_t   step_reg;
  cnt_t   tmo_reg;
  cnt_t   settle_reg;
  cnt_t   res_step_reg;
  cnt_t   res_count_reg;
  logic   res_valid_reg;
  logic   ps_en_reg;
  logic   done_reg;
  logic   err_timeout_reg;

  logic   sample_clear;
  logic   sample_en;
  logic   window_last;
  cnt_t   window_hits;

  // Counters are held at zero outside SAMPLE, so a lock loss (which drops
  // back to WAIT_LOCK) discards any partial window.
  assign sample_clear = (state_reg != ST_SAMPLE);
  assign sample_en    = (state_reg == ST_SAMPLE) && locked;

  ets_hit_counter #(
    .WINDOW (SAMPLE_COUNT)
  ) u_hit_counter (
    .free_run_clk   (free_run_clk),
    .free_run_rst_n (free_run_rst_n),
    .clear          (sample_clear),
    .enable         (sample_en),
    .sample_bit     (cmp_data),
    .window_last    (window_last),
    .window_hits    (window_hits)
  );

  always_ff @(posedge free_run_clk) begin
    if (!free_run_rst_n) begin
      state_reg       <= ST_IDLE;
      step_reg        <= '0;
      tmo_reg         <= '0;
      settle_reg      <= '0;
      res_step_reg    <= '0;
      res_count_reg   <= '0;
      res_valid_reg   <= 1'b0;
      ps_en_reg       <= 1'b0;
      done_reg        <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the transition that owns them.
      ps_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (abort) begin
        state_reg     <= ST_IDLE;
        res_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              state_reg       <= ST_WAIT_LOCK;
              step_reg        <= '0;
              err_timeout_reg <= 1'b0;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked) state_reg <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            if (!locked) begin
              state_reg <= ST_WAIT_LOCK;
            end else if (window_last) begin
              state_reg     <= ST_EMIT;
              res_valid_reg <= 1'b1;
              res_step_reg  <= step_reg;
              res_count_reg <= window_hits;
            end
          end
          ST_EMIT: begin
            // res_valid_reg is always high here, so ready alone completes the transfer.
            if (res.res_ready) begin
              res_valid_reg <= 1'b0;
              if (step_reg == STEP_LAST) begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= ST_SHIFT;
                ps_en_reg <= 1'b1;
              end
            end
          end
          ST_SHIFT: begin
            state_reg <= ST_WAIT_PS;
            tmo_reg   <= '0;
          end
          ST_WAIT_PS: begin
            if (ps_done) begin
              state_reg  <= ST_SETTLE;
              step_reg   <= step_reg + cnt_t'(1);
              settle_reg <= '0;
            end else if (tmo_reg == TMO_LAST) begin
              state_reg       <= ST_IDLE;
              err_timeout_reg <= 1'b1;
            end else begin
              tmo_reg <= tmo_reg + cnt_t'(1);
            end
          end
          ST_SETTLE: begin
            if (settle_reg == SETTLE_LAST) state_reg <= ST_WAIT_LOCK;
            else                           settle_reg <= settle_reg + cnt_t'(1);
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign ps_en         = ps_en_reg;
  assign ps_incdec     = 1'b1;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign err_timeout   = err_timeout_reg;
  assign res.res_valid = res_valid_reg;
  assign res.res_step  = res_step_reg;
  assign res.res_count = res_count_reg;

endmodule

// File: tb/tb_ets_phase_sweeper.sv
// tb_ets_phase_sweeper
// Directed sweep scenarios with random comparator data; expected results are
// derived from the sweep timing rules and the recorded comparator history.
module tb_ets_phase_sweeper;

  localparam int STEPS   = 4;
  localparam int SAMPLES = 8;
  localparam int SETTLE  = 2;
  localparam int TMO     = 10;

  logic free_run_clk = 1'b0;
  logic free_run_rst_n;
  logic start, abort, locked, cmp_data, ps_done;
  logic ps_en, ps_incdec, busy, done, err_timeout;

  ets_phase_sweeper_if res_if ();

  ets_phase_sweeper #(
    .STEP_COUNT    (STEPS),
    .SAMPLE_COUNT  (SAMPLES),
    .SETTLE_CYCLES (SETTLE),
    .PS_TIMEOUT    (TMO)
  ) dut (
    .free_run_clk   (free_run_clk),
    .free_run_rst_n (free_run_rst_n),
    .start          (start),
    .abort          (abort),
    .locked         (locked),
    .cmp_data       (cmp_data),
    .ps_en          (ps_en),
    .ps_incdec      (ps_incdec),
    .ps_done        (ps_done),
    .busy           (busy),
    .done           (done),
    .err_timeout    (err_timeout),
    .res            (res_if)
  );

  always #5 free_run_clk = ~free_run_clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit hist_cmp [int];

  int ps_en_cnt = 0, done_cnt = 0, rise_cnt = 0, psdone_cnt = 0;
  int ps_due = -1;
  bit auto_ps_done = 1'b1;
  bit cmp_random = 1'b0;
  bit prev_valid = 1'b0;
  bit prev_ps_en = 1'b0;
  int exp_rise = -1;
  int exp_step = 0;
  int stall_step = -1, stall_len = 0, stall_left = 0;
  int drop_psdone = 0, drop_start = -1;
  logic [15:0] held_step, held_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int window_ones(input int rise_cyc);
    int n;
    n = 0;
    for (int i = rise_cyc - SAMPLES; i < rise_cyc; i++) n += int'(hist_cmp[i]);
    return n;
  endfunction

  // One clock: observe outputs just after the edge, then drive the next interval.
  task automatic cyc_step();
    bit in_ready, in_abort, in_rst, in_valid;
    in_ready = res_if.res_ready;
    in_abort = abort;
    in_rst   = free_run_rst_n;
    in_valid = prev_valid;
    @(posedge free_run_clk);
    #1;
    cyc++;
    if (in_valid && !in_ready && !in_abort && in_rst) begin
      check("hold_valid", res_if.res_valid, 1);
      check("hold_step", res_if.res_step, held_step);
      check("hold_count", res_if.res_count, held_count);
      check("hold_no_ps_en", ps_en, 0);
    end
    if (res_if.res_valid && !in_valid) begin
      check("res_step", res_if.res_step, exp_step);
      check("res_count", res_if.res_count, window_ones(cyc));
      check("result_latency", cyc, exp_rise);
      held_step  = res_if.res_step;
      held_count = res_if.res_count;
      rise_cnt++;
      if (exp_step == stall_step) stall_left = stall_len;
    end
    if (ps_en) begin
      check("ps_en_single_cycle", prev_ps_en, 0);
      ps_en_cnt++;
      ps_due = cyc + 3;
    end
    if (done) done_cnt++;
    ps_done = auto_ps_done && (cyc == ps_due);
    if (ps_done) begin
      psdone_cnt++;
      exp_rise = cyc + SETTLE + 2 + SAMPLES;
      if (psdone_cnt == drop_psdone) begin
        drop_start = cyc + SETTLE + 2 + 3;        // 4th sample cycle of the next step
        exp_rise   = drop_start + 3 + 1 + SAMPLES;
      end
    end
    if (drop_start >= 0) locked = !(cyc >= drop_start && cyc < drop_start + 3);
    cmp_data = cmp_random ? 1'($urandom_range(0, 1)) : 1'b1;
    hist_cmp[cyc] = cmp_data;
    res_if.res_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    if (res_if.res_valid && res_if.res_ready) exp_step++;
    prev_valid = res_if.res_valid;
    prev_ps_en = ps_en;
  endtask

  task automatic do_start();
    start    = 1'b1;
    exp_step = 0;
    exp_rise = cyc + 2 + SAMPLES;
    cyc_step();
    start = 1'b0;
  endtask

  task automatic reset_counts();
    ps_en_cnt  = 0;
    done_cnt   = 0;
    rise_cnt   = 0;
    psdone_cnt = 0;
  endtask

  task automatic run_until_done(input int budget);
    int target, n;
    target = done_cnt + 1;
    n = 0;
    while (done_cnt < target && n < budget) begin
      cyc_step();
      n++;
    end
    if (done_cnt < target) check("done_wait_expired", done_cnt, target);
  endtask

  task automatic wait_ps_en(input int target, input int budget);
    int n;
    n = 0;
    while (ps_en_cnt < target && n < budget) begin
      cyc_step();
      n++;
    end
    if (ps_en_cnt < target) check("ps_en_wait_expired", ps_en_cnt, target);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ps_en"}, ps_en, 0);
    check({pfx, "_ps_incdec"}, ps_incdec, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_err_timeout"}, err_timeout, 0);
    check({pfx, "_res_valid"}, res_if.res_valid, 0);
    check({pfx, "_res_step"}, res_if.res_step, 0);
    check({pfx, "_res_count"}, res_if.res_count, 0);
  endtask

  initial begin
    int n, pe;
    free_run_rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; locked = 1'b1; cmp_data = 1'b0; ps_done = 1'b0;
    res_if.res_ready = 1'b1;
    repeat (3) cyc_step();
    check_reset_outputs("reset");
    free_run_rst_n = 1'b1;
    cyc_step();

    // Full sweep, comparator constantly 1.
    reset_counts();
    do_start();
    run_until_done(400);
    repeat (5) cyc_step();
    check("sweep_results", rise_cnt, STEPS);
    check("sweep_ps_en", ps_en_cnt, STEPS - 1);
    check("sweep_done", done_cnt, 1);
    check("sweep_busy_after", busy, 0);

    // Random comparator data with backpressure on step 1.
    cmp_random = 1'b1;
    stall_step = 1; stall_len = 5;
    reset_counts();
    do_start();
    run_until_done(400);
    check("bp_results", rise_cnt, STEPS);
    check("bp_ps_en", ps_en_cnt, STEPS - 1);
    stall_step = -1;

    // Lock loss during step 2 sampling.
    reset_counts();
    drop_psdone = 2;
    do_start();
    run_until_done(400);
    check("lock_results", rise_cnt, STEPS);
    check("lock_done", done_cnt, 1);
    drop_psdone = 0; drop_start = -1; locked = 1'b1;

    // Phase-shift timeout.
    reset_counts();
    auto_ps_done = 1'b0;
    do_start();
    wait_ps_en(1, 100);
    repeat (TMO) cyc_step();
    check("tmo_err_before", err_timeout, 0);
    check("tmo_busy_before", busy, 1);
    cyc_step();
    check("tmo_err_set", err_timeout, 1);
    check("tmo_idle", busy, 0);
    repeat (5) cyc_step();
    check("tmo_err_sticky", err_timeout, 1);
    check("tmo_no_done", done_cnt, 0);
    check("tmo_ps_en", ps_en_cnt, 1);
    auto_ps_done = 1'b1;
    reset_counts();
    do_start();
    check("tmo_err_cleared", err_timeout, 0);
    check("tmo_restart_busy", busy, 1);
    run_until_done(400);
    check("tmo_restart_results", rise_cnt, STEPS);

    // Abort while step 1 result is pending.
    reset_counts();
    stall_step = 1; stall_len = 1000;
    do_start();
    n = 0;
    while (!(res_if.res_valid && res_if.res_step == 16'd1) && n < 200) begin
      cyc_step();
      n++;
    end
    if (n >= 200) check("abort_wait_expired", n, 0);
    abort = 1'b1;
    cyc_step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_if.res_valid, 0);
    stall_left = 0; stall_step = -1;
    pe = ps_en_cnt;
    repeat (20) cyc_step();
    check("abort_no_ps_en", ps_en_cnt, pe);
    check("abort_no_done", done_cnt, 0);
    reset_counts();
    do_start();
    run_until_done(400);
    check("abort_restart_results", rise_cnt, STEPS);

    // Reset in WAIT_PS (after step 1) coinciding with ps_done.
    reset_counts();
    do_start();
    wait_ps_en(2, 200);
    auto_ps_done = 1'b0;
    cyc_step();
    free_run_rst_n = 1'b0;
    ps_done = 1'b1;
    cyc_step();
    check_reset_outputs("rst_wait_ps");
    free_run_rst_n = 1'b1;
    repeat (20) cyc_step();
    check("rst_no_ps_en", ps_en_cnt, 2);
    check("rst_idle", busy, 0);
    auto_ps_done = 1'b1;
    reset_counts();
    do_start();
    run_until_done(400);
    check("rst_restart_results", rise_cnt, STEPS);
    check("rst_restart_done", done_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
